traffic_state_sequencer: RTL
============================

# traffic_state_sequencer

Registered next-state and dwell-timer stage of the highway/farm-road traffic light controller. It sequences the four light phases from a farm-road car sensor and a timebase tick, holding each phase for its programmed number of ticks. It drives the 2-bit phase code consumed directly by the light output decoder (S0 HG/FR, S1 HY/FR, S2 HR/FG, S3 HR/FY), plus a phase-change strobe and the dwell count for status and debug.

## Interface

- LONG_T, 20: ticks in a long phase (highway green minimum; farm green maximum)
- SHORT_T, 4: ticks in a yellow phase
- TW, 8: dwell counter width. Legal range: 2 <= SHORT_T < LONG_T <= 2^TW.

- Clk_i  input  1  single clock; all state updates on its rising edge
- RstN_i  input  1  reset, synchronous, active-low
- Tick_i  input  1  timebase enable; the timer and transitions advance only on cycles where it is 1
- Car_i  input  1  farm-road car present, already synchronised to Clk_i
- CurrentState_o  output  2  registered phase code: 00=S0 HG, 01=S1 HY, 10=S2 FG, 11=S3 FY
- StateChange_o  output  1  registered one-cycle pulse, high in the first cycle of a new phase
- TimerCount_o  output  TW  registered ticks elapsed in the current phase

## Operation

- Internal state: phase register P[1:0] and dwell counter T[TW-1:0]. The outputs are P, T and the strobe register.
- Inputs are evaluated only on cycles with Tick_i=1. On Tick_i=0 cycles, P and T hold and StateChange_o is driven 0.
- Exit conditions on a tick cycle:
  - S0: Car_i=1 and T==LONG_T-1, then go to S1.
  - S1: T==SHORT_T-1, then go to S2.
  - S2: T==LONG_T-1 or Car_i=0, then go to S3. Car_i=0 on the first tick of S2 exits immediately, so the minimum S2 dwell is 1 tick.
  - S3: T==SHORT_T-1, then go to S0.
- On an exit: P <= next, T <= 0, strobe <= 1.
- Otherwise on a tick: P holds, strobe <= 0, and T <= T+1 saturating at LONG_T-1. Saturation matters only in S0 with no car, where T sits at LONG_T-1 until Car_i=1.
- Encodings P=00..11 are all valid, so there is no illegal-state recovery.
- Car_i is sampled only on tick cycles. A car pulse wholly between ticks is ignored by design.

## Timing

- Reset: when RstN_i=0 at a rising edge, then after that edge CurrentState_o=00, TimerCount_o=0 and StateChange_o=0.
  - Reset wins over any simultaneous tick or exit.
  - Reset mid-phase (for example in S2) returns to S0 at the next edge, with no yellow phase.
  - The first tick after release counts as T 0→1.
- Latency: an exit decided on tick cycle k appears on CurrentState_o after edge k. StateChange_o is high for exactly that one following cycle, aligned with the new code.
- Phase duration with Tick_i tied high:
  - S1 and S3 last exactly SHORT_T cycles.
  - S0 lasts at least LONG_T cycles.
  - S2 lasts at most LONG_T cycles.
- With a sparse tick, durations are counted in ticks, not cycles.
- Car_i changes on the same cycle as an exit tick use the sampled value at that edge. Combinational Car_i→P timing is one edge.
- Decoder path: CurrentState_o is registered, so the light outputs change one edge after the exit tick, with no glitches.

## Test plan

- Reset: hold RstN_i=0 for 3 cycles with Tick_i=1 and Car_i=1 → CurrentState_o=00, TimerCount_o=0 and StateChange_o=0 throughout.
- No traffic: Car_i=0 for 100 cycles with Tick_i=1 → stays 00, TimerCount_o counts 0..19 and then holds at 19, no strobe.
- Full cycle: Car_i=1 continuously with Tick_i=1 → 00 for 20 cycles, 01 for 4, 10 for 20, 11 for 4, then 00. There is exactly one strobe cycle at each of the 4 boundaries.
- Early farm exit: Car_i=1 until the 6th cycle of S2, then 0 → S2 exits on that tick after 6 cycles, then S3 for 4 cycles, then S0.
- Sparse tick: Tick_i high every 4th cycle, Car_i=1, and a 2-cycle Car_i=0 glitch placed between ticks in S2 → S1 lasts 16 cycles and S2 the full 80. The glitch is ignored and the strobe lasts 1 cycle.
- Mid-phase reset: assert RstN_i=0 for 1 cycle at tick 10 of S2 → 00 with TimerCount_o=0 after that edge. Normal sequencing resumes, and S0 needs 20 ticks before it can exit.

Source files
------------

// File: rtl/traffic_state_sequencer.sv
// Phase register and dwell timer for the highway/farm-road traffic light controller.
// Sequences HG -> HY -> FG -> FY -> HG on timebase ticks, driven by the farm-road car sensor.
module traffic_state_sequencer #(
   parameter int unsigned LONG_T  = 20,
   parameter int unsigned SHORT_T = 4,
   parameter int unsigned TW      = 8
) (
   input  logic          Clk_i,
   input  logic          RstN_i,
   input  logic          Tick_i,
   input  logic          Car_i,
   output logic [1:0]    CurrentState_o,
   output logic          StateChange_o,
   output logic [TW-1:0] TimerCount_o
);

   // Encodings are consumed directly by the light decoder.
   typedef enum logic [1:0] {
      StHwyGreen  = 2'b00,
      StHwyYellow = 2'b01,
      StFarmGreen = 2'b10,
      StFarmYellow = 2'b11
   } state_e;

   localparam logic [TW-1:0] LongLast  = TW'(LONG_T - 1);
   localparam logic [TW-1:0] ShortLast = TW'(SHORT_T - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          change_q, change_d;
   logic          leave;
   state_e        next_state;

   // Exit decision and next phase; only meaningful on tick cycles.
   always_comb begin
      leave      = 1'b0;
      next_state = state_q;
      unique case (state_q)
         StHwyGreen: begin
            leave      = Car_i && (timer_q == LongLast);
            next_state = StHwyYellow;
         end
         StHwyYellow: begin
            leave      = (timer_q == ShortLast);
            next_state = StFarmGreen;
         end
         StFarmGreen: begin
            // An empty farm road ends farm green immediately, even on its first tick.
            leave      = !Car_i || (timer_q == LongLast);
            next_state = StFarmYellow;
         end
         StFarmYellow: begin
            leave      = (timer_q == ShortLast);
            next_state = StHwyGreen;
         end
         default: begin
            leave      = 1'b0;
            next_state = state_q;
         end
      endcase
   end

   // Next-state for phase, dwell timer and change strobe.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      change_d = 1'b0;
      if (Tick_i) begin
         if (leave) begin
            state_d  = next_state;
            timer_d  = '0;
            change_d = 1'b1;
         end else if (timer_q != LongLast) begin
            // Saturation only bites in highway green while no car is waiting.
            timer_d = timer_q + 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge Clk_i) begin
      if (!RstN_i) begin
         state_q  <= StHwyGreen;
         timer_q  <= '0;
         change_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         change_q <= change_d;
      end
   end

   assign CurrentState_o = state_q;
   assign StateChange_o  = change_q;
   assign TimerCount_o   = timer_q;

endmodule
